// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: ALU op encodings, per-stage payload structs,
// their packed widths, and the NOP/bubble payloads used as stage-register reset values.
package cpu_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_SZ_B = 2'd0,
    MEM_SZ_H = 2'd1,
    MEM_SZ_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        mem_rd;
    logic        mem_wr;
    mem_size_e   mem_size;
    logic        reg_wr;
    logic        is_branch;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    mem_size_e   mem_size;
    logic        reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } mem_wb_t;

  localparam int unsigned ID_EX_W  = $bits(id_ex_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

  // Bubbles carry no side effects: all write/memory enables are zero.
  localparam id_ex_t  ID_EX_NOP  = '0;
  localparam ex_mem_t EX_MEM_NOP = '0;
  localparam mem_wb_t MEM_WB_NOP = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry skid storage for pipe_stage_reg; holds one payload while the
// output register is stalled. Used only when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf #(
  parameter int unsigned DATA_W = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      data_q <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush, and a
// saturating stall counter. Optional 1-entry skid buffer under PIPE_STAGE_SKID_EN.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W          = 160,
  parameter logic [DATA_W-1:0] RESET_DATA      = '0,
  parameter bit                CLEAR_ON_BUBBLE = 1'b1,
  parameter int unsigned       CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic accept;
  logic stalled;
  logic xfer_out;

  assign stalled  = out_valid_q & ~out_ready;
  assign xfer_out = out_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_push;
  logic              skid_pop;
  logic [DATA_W-1:0] skid_data;

  // in_ready comes straight from the skid flop, breaking the out_ready->in_ready path.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign skid_push = accept & stalled & ~flush;
  assign skid_pop  = xfer_out & skid_valid;

  pipe_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .data_i  (in_data),
    .data_o  (skid_data),
    .valid_o (skid_valid)
  );
`else
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = RESET_DATA;
`ifdef PIPE_STAGE_SKID_EN
    end else if (skid_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = skid_data;
`endif
    end else if (accept && !stalled) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end else if (xfer_out) begin
      out_valid_d = 1'b0;
      if (CLEAR_ON_BUBBLE) begin
        out_data_d = RESET_DATA;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stalled && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= RESET_DATA;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (DATA_W=8, CNT_W=4), valid with or without
// PIPE_STAGE_SKID_EN; two instances cover CLEAR_ON_BUBBLE=1 (a) and =0 (b).
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [7:0] out_data_a, out_data_b;
  logic [3:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (8), .RESET_DATA (8'h00), .CLEAR_ON_BUBBLE (1'b1), .CNT_W (4)
  ) u_dut_a (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready_a), .in_data (in_data),
    .out_valid (out_valid_a), .out_ready (out_ready), .out_data (out_data_a),
    .stall_cnt (cnt_a)
  );

  pipe_stage_reg #(
    .DATA_W (8), .RESET_DATA (8'h00), .CLEAR_ON_BUBBLE (1'b0), .CNT_W (4)
  ) u_dut_b (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready_b), .in_data (in_data),
    .out_valid (out_valid_b), .out_ready (out_ready), .out_data (out_data_b),
    .stall_cnt (cnt_b)
  );

  // Reference model: stage contents as a FIFO of up to CAP entries.
  logic [7:0]  mq[$];
  logic [7:0]  last_a, last_b;
  int unsigned mcnt;
  bit          pend;
  int          errors = 0;
  int          checks = 0;

  // Upstream rule: a pending offer must stay put until taken (unless flushed/reset).
  bit         a_pend = 1'b0;
  logic [7:0] a_data;
  always @(posedge clk) begin
    if (a_pend) begin
      assert (in_valid && in_data == a_data) else $error("upstream dropped pending offer");
    end
    a_pend <= in_valid && !in_ready_a && !rst && !flush;
    a_data <= in_data;
  end

  function automatic bit m_in_ready();
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(output bit acc);
    bit         ir;
    logic [7:0] popped;
    logic [7:0] exp_a, exp_b;
    @(negedge clk);
    ir = m_in_ready();
    if (!rst) begin
      chk("in_ready_a", in_ready_a, ir);
      chk("in_ready_b", in_ready_b, ir);
    end
    acc = in_valid && ir && !rst && !flush;
    if (rst) begin
      mq.delete();
      last_a = 8'h00;
      last_b = 8'h00;
      mcnt = 0;
    end else begin
      if (mq.size() > 0 && !out_ready && mcnt < 15) mcnt++;
      if (flush) begin
        mq.delete();
        last_a = 8'h00;
        last_b = 8'h00;
      end else begin
        if (mq.size() > 0 && out_ready) begin
          popped = mq.pop_front();
          last_a = 8'h00;
          last_b = popped;
        end
        if (in_valid && ir) mq.push_back(in_data);
      end
    end
    pend = in_valid && !ir && !rst && !flush;
    @(posedge clk);
    #1;
    if (mq.size() > 0) begin
      exp_a = mq[0];
      exp_b = mq[0];
    end else begin
      exp_a = last_a;
      exp_b = last_b;
    end
    chk("out_valid_a", out_valid_a, mq.size() > 0);
    chk("out_valid_b", out_valid_b, mq.size() > 0);
    chk("out_data_a", out_data_a, exp_a);
    chk("out_data_b", out_data_b, exp_b);
    chk("stall_cnt_a", cnt_a, mcnt);
    chk("stall_cnt_b", cnt_b, mcnt);
  endtask

  typedef struct {
    bit         rst;
    bit         in_valid;
    logic [7:0] in_data;
    bit         out_ready;
    bit         exp_valid;
    logic [7:0] exp_data;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vt[$];
  bit   acc;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    pend = 1'b0;

    // Reset and streaming vectors
    vt.push_back('{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 4'h0});
    vt.push_back('{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 4'h0});
    for (int k = 1; k <= 8; k++)
      vt.push_back('{1'b0, 1'b1, 8'(k), 1'b1, 1'b1, 8'(k), 4'h0});
    vt.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'h0});

    foreach (vt[i]) begin
      rst = vt[i].rst; in_valid = vt[i].in_valid; in_data = vt[i].in_data;
      out_ready = vt[i].out_ready;
      cycle(acc);
      chk("vec_valid", out_valid_a, vt[i].exp_valid);
      chk("vec_data", out_data_a, vt[i].exp_data);
      chk("vec_cnt", cnt_a, vt[i].exp_cnt);
    end

    // Stall with 11 held while 22 is offered
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    cycle(acc);
    in_data = 8'h22; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      if (acc) in_valid = 1'b0;
    end
    chk("t3_hold_data", out_data_a, 8'h11);
    chk("t3_hold_valid", out_valid_a, 1'b1);
    chk("t3_cnt", cnt_a, 4'h3);
    chk("t3_in_ready", in_ready_a, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    chk("t3_skid_taken", in_valid, 1'b0);
`else
    chk("t3_offer_pending", in_valid, 1'b1);
`endif
    out_ready = 1'b1;
    cycle(acc);
    if (acc) in_valid = 1'b0;
    chk("t3_second_data", out_data_a, 8'h22);
    chk("t3_second_valid", out_valid_a, 1'b1);
    cycle(acc);
    chk("t3_drain_valid", out_valid_a, 1'b0);
    chk("t3_drain_data_a", out_data_a, 8'h00);
    chk("t3_drain_data_b", out_data_b, 8'h22);

    // Flush on the same edge as accepting 33 with 44 in stage
    in_valid = 1'b1; in_data = 8'h44;
    cycle(acc);
    in_data = 8'h33; flush = 1'b1;
    cycle(acc);
    chk("t4_valid", out_valid_a, 1'b0);
    chk("t4_data_a", out_data_a, 8'h00);
    chk("t4_data_b", out_data_b, 8'h00);
    flush = 1'b0; in_valid = 1'b0;
    cycle(acc);
    chk("t4_after_valid", out_valid_a, 1'b0);
    chk("t4_after_data", out_data_b, 8'h00);

    // Long stall saturates the counter
    in_valid = 1'b1; in_data = 8'h66;
    cycle(acc);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) cycle(acc);
    chk("t5_cnt_sat", cnt_a, 4'hF);
    chk("t5_data", out_data_a, 8'h66);
    out_ready = 1'b1;
    cycle(acc);
    chk("t5_cnt_nowrap", cnt_a, 4'hF);

    // Single payload then idle: clear vs hold on bubble
    in_valid = 1'b1; in_data = 8'h55;
    cycle(acc);
    chk("t6_data_a", out_data_a, 8'h55);
    chk("t6_data_b", out_data_b, 8'h55);
    in_valid = 1'b0;
    cycle(acc);
    chk("t6_bubble_a", out_data_a, 8'h00);
    chk("t6_bubble_b", out_data_b, 8'h55);
    chk("t6_bubble_valid_b", out_valid_b, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom % 64) == 0;
      flush = ($urandom % 16) == 0;
      out_ready = ($urandom % 3) != 0;
      if (!pend) begin
        in_valid = ($urandom % 3) != 0;
        in_data  = 8'($urandom);
      end
      cycle(acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
